// File: rtl/sram_burst_pkg.sv
// sram_burst_pkg: shared sizes and FSM encoding for the frame-buffer SRAM burst controller.
package sram_burst_pkg;
    localparam int WORDSIZE     = 80;
    localparam int ADDRESSSIZE  = 15;
    localparam int LENSIZE      = 16;
    localparam int RDFIFO_DEPTH = 4;
    localparam int RASIZE       = 11;
    localparam int CASIZE       = 4;
    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;
endpackage

// File: rtl/sram_rd_fifo.sv
// sram_rd_fifo: small synchronous FIFO holding SRAM read words until the consumer takes them.
module sram_rd_fifo #(
    parameter int WIDTH = 80,
    parameter int DEPTH = 4
) (
    input  logic                         iClk,
    input  logic                         iReset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign empty   = count == '0;
    assign full    = count == CW'(DEPTH);
    assign dout    = mem[rd_ptr];
    always_ff @(posedge iClk or negedge iReset)
        if (!iReset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr == AW'(DEPTH-1) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr == AW'(DEPTH-1) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    always_ff @(posedge iClk)
        if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/sram_burst_ctrl.sv
// sram_burst_ctrl: single-command burst initiator for the 32768x80 frame-buffer SRAM.
// Read words pass through a small FIFO so the consumer can stall without losing data.
module sram_burst_ctrl
    import sram_burst_pkg::*;
(
    input  logic                   iClk,
    input  logic                   iReset,
    input  logic                   iCmdValid,
    output logic                   oCmdReady,
    input  logic                   iCmdWrite,
    input  logic [ADDRESSSIZE-1:0] iCmdAddr,
    input  logic [LENSIZE-1:0]     iCmdLen,
    input  logic                   iWrValid,
    output logic                   oWrReady,
    input  logic [WORDSIZE-1:0]    iWrData,
    output logic                   oRdValid,
    input  logic                   iRdReady,
    output logic [WORDSIZE-1:0]    oRdData,
    output logic                   oDone,
    output logic                   oNCE,
    output logic                   oNWRT,
    output logic [RASIZE-1:0]      oRA,
    output logic [CASIZE-1:0]      oCA,
    output logic [WORDSIZE-1:0]    oDIN,
    input  logic [WORDSIZE-1:0]    iDO
);
    localparam int CW = $clog2(RDFIFO_DEPTH+1);
    state_t                 state;
    logic [ADDRESSSIZE-1:0] addr;
    logic [LENSIZE-1:0]     rem, pend;
    logic [1:0]             infl;
    logic [CW-1:0]          fifo_count;
    logic [CW:0]            occ;
    logic                   fifo_empty, fifo_full;
    logic                   wr_beat, rd_issue, pop;
    assign oCmdReady = state == IDLE;
    assign oWrReady  = state == WRITE;
    assign oDone     = state == DONE;
    assign oRdValid  = !fifo_empty;
    assign pop       = !fifo_empty && iRdReady;
    assign wr_beat   = state == WRITE && iWrValid;
    // Words already in the FIFO plus reads still in the SRAM pipe must fit in the FIFO.
    assign occ       = {1'b0, fifo_count} + (CW+1)'(infl[0]) + (CW+1)'(infl[1]);
    assign rd_issue  = state == READ && rem != '0 && !fifo_full && occ < (CW+1)'(RDFIFO_DEPTH);
    always_ff @(posedge iClk or negedge iReset)
        if (!iReset) begin
            state <= IDLE;
            addr  <= '0;
            rem   <= '0;
            pend  <= '0;
            infl  <= '0;
            oNCE  <= 1'b1;
            oNWRT <= 1'b1;
            oRA   <= '0;
            oCA   <= '0;
            oDIN  <= '0;
        end else begin
            infl  <= {infl[0], rd_issue};
            oNCE  <= !(wr_beat || rd_issue);
            oNWRT <= !wr_beat;
            if (wr_beat || rd_issue) begin
                {oRA, oCA} <= addr;
                addr       <= addr + 1'b1;
                rem        <= rem - 1'b1;
            end
            if (wr_beat) oDIN <= iWrData;
            case (state)
                IDLE:
                    if (iCmdValid) begin
                        addr  <= iCmdAddr;
                        rem   <= iCmdLen;
                        pend  <= iCmdLen;
                        state <= iCmdLen == '0 ? DONE : iCmdWrite ? WRITE : READ;
                    end
                WRITE:
                    if (wr_beat && rem == LENSIZE'(1)) state <= DONE;
                READ:
                    if (pop) begin
                        pend <= pend - 1'b1;
                        if (pend == LENSIZE'(1)) state <= DONE;
                    end
                default: state <= IDLE;
            endcase
        end
    sram_rd_fifo #(.WIDTH(WORDSIZE), .DEPTH(RDFIFO_DEPTH)) u_fifo (
        .iClk   (iClk),
        .iReset (iReset),
        .push   (infl[1]),
        .pop    (pop),
        .din    (iDO),
        .dout   (oRdData),
        .count  (fifo_count),
        .empty  (fifo_empty),
        .full   (fifo_full)
    );
endmodule

// File: tb/tb_sram_burst_ctrl.sv
// tb_sram_burst_ctrl: scoreboard bench with a behavioural SRAM model on the pins.
module tb_sram_burst_ctrl;
    logic        iClk = 0, iReset = 1, iCmdValid = 0, iCmdWrite = 0, iWrValid = 0, iRdReady = 0;
    logic [14:0] iCmdAddr = 0;
    logic [15:0] iCmdLen = 0;
    logic [79:0] iWrData = 0, iDO;
    logic        oCmdReady, oWrReady, oRdValid, oDone, oNCE, oNWRT;
    logic [79:0] oRdData, oDIN;
    logic [10:0] oRA;
    logic [3:0]  oCA;
    int checks = 0, errors = 0, cyc = 0, acc = 0;
    int nce_low = 0, wr_cyc = 0, done_cnt = 0, done_base = 0, done_cyc = 0;
    int pops = 0, first_rv = -1, first_pop = -1, last_pop = -1, max_cnt = 0;
    int p0, w0, n0;
    bit toggle = 0;
    logic [79:0] sram [0:32767];
    logic [79:0] ref_mem [int];
    logic [95:0] wq [$];
    logic [79:0] rq [$];

    sram_burst_ctrl dut (
        .iClk(iClk), .iReset(iReset), .iCmdValid(iCmdValid), .oCmdReady(oCmdReady),
        .iCmdWrite(iCmdWrite), .iCmdAddr(iCmdAddr), .iCmdLen(iCmdLen),
        .iWrValid(iWrValid), .oWrReady(oWrReady), .iWrData(iWrData),
        .oRdValid(oRdValid), .iRdReady(iRdReady), .oRdData(oRdData), .oDone(oDone),
        .oNCE(oNCE), .oNWRT(oNWRT), .oRA(oRA), .oCA(oCA), .oDIN(oDIN), .iDO(iDO)
    );

    always #5 iClk = ~iClk;
    always @(posedge iClk) cyc <= cyc + 1;
    always @(posedge iClk)
        if (!oNCE) begin
            if (!oNWRT) sram[{oRA, oCA}] <= oDIN;
            else iDO <= sram[{oRA, oCA}];
        end

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    always @(negedge iClk)
        if (iReset) begin
            iRdReady = toggle ? ~iRdReady : 1'b1;
            if (!oNCE) nce_low++;
            if (!oNCE && !oNWRT) begin
                wr_cyc++;
                check("wr_pin", {1'b0, oRA, oCA, oDIN}, wq.size() != 0 ? wq.pop_front() : 96'bx);
            end
            if (oRdValid) begin
                if (first_rv < 0) first_rv = cyc;
                if (iRdReady) begin
                    check("rd_data", 96'(oRdData), rq.size() != 0 ? 96'(rq.pop_front()) : 96'bx);
                    pops++;
                    if (first_pop < 0) first_pop = cyc;
                    last_pop = cyc;
                end
            end
            if (oDone) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (int'(dut.u_fifo.count) > max_cnt) max_cnt = int'(dut.u_fifo.count);
        end

    task automatic cmd(input logic wr, input logic [14:0] a, input logic [15:0] n);
        @(negedge iClk); #1;
        check("cmd_ready", 96'(oCmdReady), 96'd1);
        done_base = done_cnt;
        iCmdValid = 1; iCmdWrite = wr; iCmdAddr = a; iCmdLen = n;
        @(negedge iClk); #1;
        iCmdValid = 0; acc = cyc; first_rv = -1; first_pop = -1;
    endtask

    task automatic wait_done(input int lim);
        for (int i = 0; i < lim && done_cnt == done_base; i++) begin
            @(negedge iClk); #1;
        end
        check("done_seen", 96'(done_cnt - done_base), 96'd1);
    endtask

    task automatic wr_burst(input logic [14:0] a, input int n, input logic [79:0] base);
        logic [14:0] ad;
        int w;
        w = wr_cyc;
        cmd(1'b1, a, 16'(n));
        for (int i = 0; i < n; i++) begin
            ad = a + 15'(i);
            iWrValid = 1;
            iWrData = base + 80'(i);
            ref_mem[int'(ad)] = iWrData;
            wq.push_back({1'b0, ad, iWrData});
            @(negedge iClk); #1;
        end
        iWrValid = 0;
        wait_done(20);
        check("wr_done_lat", 96'(done_cyc - acc), 96'(n));
        check("wr_cycles", 96'(wr_cyc - w), 96'(n));
    endtask

    task automatic rd_burst(input logic [14:0] a, input int n, input bit tog);
        toggle = tog;
        for (int i = 0; i < n; i++) rq.push_back(ref_mem[int'(a + 15'(i))]);
        cmd(1'b0, a, 16'(n));
        wait_done(200);
        check("rd_left", 96'(rq.size()), 96'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        #1 iReset = 0;
        #2;
        check("rst_nce", 96'(oNCE), 96'd1);
        check("rst_nwrt", 96'(oNWRT), 96'd1);
        check("rst_addr", 96'({oRA, oCA}), 96'd0);
        check("rst_din", 96'(oDIN), 96'd0);
        check("rst_rdvalid", 96'(oRdValid), 96'd0);
        check("rst_done", 96'(oDone), 96'd0);
        check("rst_wrready", 96'(oWrReady), 96'd0);
        @(negedge iClk); #2 iReset = 1;
        #1 check("rst_cmdready", 96'(oCmdReady), 96'd1);

        wr_burst(15'h0010, 4, 80'd1);
        rd_burst(15'h0010, 4, 1'b0);
        check("rd_first_lat", 96'(first_rv - acc), 96'd3);
        check("rd_stream", 96'(last_pop - first_pop), 96'd3);
        check("rd_done_lat", 96'(done_cyc - last_pop), 96'd1);

        wr_burst(15'h0014, 4, 80'd5);
        p0 = pops; max_cnt = 0;
        rd_burst(15'h0010, 8, 1'b1);
        toggle = 0;
        check("rd_toggle_count", 96'(pops - p0), 96'd8);
        check("fifo_max", 96'(max_cnt <= 4), 96'd1);

        wr_burst(15'h7FFE, 4, 80'hA0);

        n0 = nce_low;
        cmd(1'b0, 15'h0055, 16'd0);
        wait_done(10);
        check("len0_done_lat", 96'(done_cyc - acc), 96'd0);
        check("len0_nce", 96'(nce_low - n0), 96'd0);
        @(negedge iClk); #1;
        check("len0_idle", 96'(oCmdReady), 96'd1);
        check("len0_pulse", 96'(oDone), 96'd0);

        for (int i = 0; i < 8; i++) rq.push_back(ref_mem[int'(15'h0010 + 15'(i))]);
        cmd(1'b0, 15'h0010, 16'd8);
        p0 = pops;
        for (int i = 0; i < 50 && pops - p0 < 3; i++) begin
            @(negedge iClk); #1;
        end
        check("mid_pops", 96'(pops - p0), 96'd3);
        @(posedge iClk); #2 iReset = 0;
        #1;
        check("mid_rst_nce", 96'(oNCE), 96'd1);
        check("mid_rst_rdvalid", 96'(oRdValid), 96'd0);
        check("mid_rst_done", 96'(oDone), 96'd0);
        rq.delete();
        @(negedge iClk); #2 iReset = 1;
        #1 check("post_rst_cmdready", 96'(oCmdReady), 96'd1);
        rd_burst(15'h0010, 4, 1'b0);
        check("post_rst_lat", 96'(first_rv - acc), 96'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
